// File: rtl/vga_dbg_pkg.sv
// Shared defaults and FSM state encoding for the VGA register-snapshot debug block.
package vga_dbg_pkg;

  localparam int DBG_ADDR_W = 5;
  localparam int DBG_DATA_W = 32;
  localparam int DBG_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_snapshot_bank.sv
// Double-buffered register store: writes always land in the back bank,
// reads always come from the front bank selected by front_sel.
module reg_snapshot_bank
  import vga_dbg_pkg::*;
#(
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = DBG_DATA_W
) (
  input  logic              clk,
  input  logic              front_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are intentionally not reset; the top masks them with front_valid.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel) mem0[wr_addr] <= wr_data;
      else           mem1[wr_addr] <= wr_data;
    end
  end

  assign rd_data = front_sel ? mem1[rd_addr] : mem0[rd_addr];

endmodule

// File: rtl/vga_reg_snapshot.sv
// Copies the CPU register file into a back bank once per frame and swaps it
// to the debug display on the following vsync falling edge.
//
// state | meaning
// IDLE  | waiting for a frame start with freeze low
// COPY  | reading core regs 0..N-1 into the back bank, one per cycle
// DONE  | back bank complete, waiting for the next frame start to swap
module vga_reg_snapshot
  import vga_dbg_pkg::*;
#(
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = DBG_DATA_W,
  parameter int CNT_W  = DBG_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              freeze,
  output logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              front_valid,
  output logic [CNT_W-1:0]  snapshot_count
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              bank_sel_q, bank_sel_d;
  logic              front_valid_q, front_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vsync_q;
  logic              frame_start;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign frame_start = vsync_q & ~vsync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      bank_sel_q    <= 1'b0;
      front_valid_q <= 1'b0;
      cnt_q         <= '0;
      vsync_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bank_sel_q    <= bank_sel_d;
      front_valid_q <= front_valid_d;
      cnt_q         <= cnt_d;
      vsync_q       <= vsync;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_sel_d    = bank_sel_q;
    front_valid_d = front_valid_q;
    cnt_d         = cnt_q;
    wr_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start && !freeze) begin
          state_d = ST_COPY;
          idx_d   = '0;
        end
      end
      ST_COPY: begin
        // frame_start and freeze are deliberately ignored until the copy completes
        wr_en = 1'b1;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (frame_start) begin
          bank_sel_d    = ~bank_sel_q;
          front_valid_d = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
          idx_d         = '0;
          state_d       = freeze ? ST_IDLE : ST_COPY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  reg_snapshot_bank #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bank (
    .clk      (clk),
    .front_sel(bank_sel_q),
    .wr_en    (wr_en),
    .wr_addr  (idx_q),
    .wr_data  (core_data),
    .rd_addr  (disp_addr),
    .rd_data  (rd_data)
  );

  assign busy           = (state_q == ST_COPY);
  assign core_addr      = busy ? idx_q : '0;
  assign front_valid    = front_valid_q;
  assign snapshot_count = cnt_q;
  assign disp_data      = front_valid_q ? rd_data : '0;

endmodule

// File: doc/vga_reg_snapshot.md
VGA_REG_SNAPSHOT -- requirements
Module: vga_reg_snapshot

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register index width.
REQ-002 SHALL have parameter DATA_W, default 32, register value width.
REQ-003 SHALL have parameter CNT_W, default 16, snapshot counter width.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vsync  input  1  active-low frame sync from the VGA timing generator.
REQ-007 SHALL have port freeze  input  1  when high, no new copies start; the displayed snapshot is held.
REQ-008 SHALL have port core_addr  output  ADDR_W  CPU register-file debug read address.
REQ-009 SHALL have port core_data  input  DATA_W  CPU register value; combinational read, valid in the same cycle as core_addr.
REQ-010 SHALL have port disp_addr  input  ADDR_W  register index requested by the debug screen.
REQ-011 SHALL have port disp_data  output  DATA_W  snapshot value for disp_addr.
REQ-012 SHALL have port busy  output  1  high while in COPY.
REQ-013 SHALL have port front_valid  output  1  front bank holds a completed snapshot.
REQ-014 SHALL have port snapshot_count  output  CNT_W  number of bank swaps since reset.

Function
REQ-015 SHALL register vsync into vsync_q every cycle; frame_start = vsync_q & ~vsync (falling edge), acted on at the end of the same cycle.
REQ-016 SHALL hold two banks of 2^ADDR_W x DATA_W; bank_sel selects the front (display) bank; the other bank is the back (copy) bank.
REQ-017 SHALL implement FSM states IDLE, COPY, DONE.
REQ-018 In IDLE: on frame_start & ~freeze, go to COPY with idx=0; otherwise stay.
REQ-019 In COPY: drive core_addr=idx, write core_data into back[idx], idx+1 each cycle; after the write at idx=2^ADDR_W-1, go to DONE (32 cycles for default).
REQ-020 In COPY: SHALL ignore frame_start and freeze; the copy always completes.
REQ-021 In DONE: on frame_start, toggle bank_sel, set front_valid=1, increment snapshot_count (wraps modulo 2^CNT_W), then go to COPY (idx=0) if ~freeze, else to IDLE.
REQ-022 SHALL drive core_addr=0 outside COPY.
REQ-023 SHALL drive disp_data = front[disp_addr] combinationally when front_valid=1, else 0.
REQ-024 A write to the back bank SHALL never alter disp_data in the same or any later cycle until the swap.
REQ-025 freeze rising in DONE SHALL still allow the pending swap on the next frame_start, then park in IDLE.
REQ-026 busy SHALL equal (state==COPY).

Reset
REQ-027 On reset: state=IDLE, idx=0, bank_sel=0, front_valid=0, snapshot_count=0, vsync_q=1, core_addr=0, busy=0, disp_data=0.
REQ-028 Bank memory contents SHALL NOT be reset; front_valid masks them.
REQ-029 Reset asserted mid-COPY SHALL abort the copy with no swap; the first frame_start after reset starts a fresh copy.

Structure
REQ-030 Package vga_dbg_pkg SHALL hold ADDR_W/DATA_W/CNT_W defaults and the FSM state encoding (IDLE=0, COPY=1, DONE=2).
REQ-031 The dual-bank storage SHALL be a sub-module reg_snapshot_bank (one write port, one combinational read port, bank-select inputs).

Verification
REQ-032 Reset, then core_data=0x1000_0000+addr, vsync falling edge -> busy high 32 cycles, core_addr 0..31, front_valid stays 0, disp_data=0.
REQ-033 Second vsync falling edge -> snapshot_count=1, front_valid=1, disp_addr=5 gives 0x1000_0005, a new copy starts (busy=1).
REQ-034 Change core_data to 0x2000_0000+addr during the second copy -> disp_data unchanged (0x1000_00xx) until the third edge, then 0x2000_00xx.
REQ-035 freeze=1 before third edge -> swap occurs (count=2), state IDLE; further edges leave count=2 and disp_data fixed.
REQ-036 Second vsync falling edge injected 10 cycles into COPY -> copy runs all 32 cycles, no swap, count unchanged.
REQ-037 reset pulse at copy cycle 16 -> all outputs at reset values next cycle; next edge restarts at core_addr=0.
